bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, N-slave arbiter/router for the team's serial bus (1-bit BUS_OUT/BUS_IN, RW, ACK, SBSY).
- Grants the bus to one master at a time with round-robin priority, and decodes a 2-bit slave ID that the master sends serially after the grant.
- Asserts AD_SEL to the addressed slave and routes serial data, RW, ACK and SBSY between the owner and that slave until the transaction ends.
- Sits between the master blocks and the slave blocks (2K/4K memory slaves).

Parameters:
- N_SLAVE, 3, number of slave ports; slave IDs 0..N_SLAVE-1 are valid.
- ID_BITS, 2, width of the serial slave ID.
- TIMEOUT, 255, maximum CONNECT cycles allowed before the selected slave asserts SBSY.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- M_REQ  in  [1:0]  bus request per master; held high for the whole transaction
- M_GNT  out  [1:0]  grant per master; registered; one-hot or zero
- M_BUS_OUT  in  [1:0]  serial bit, master to bus
- M_RW  in  [1:0]  read/write per master (1 = write)
- M_BUS_IN  out  [1:0]  serial bit, bus to master; 0 when not owner
- M_ACK  out  [1:0]  slave ACK routed to the owner; 0 otherwise
- M_SBSY  out  [1:0]  slave SBSY routed to the owner; 0 otherwise
- M_ERR  out  [1:0]  1-cycle pulse: invalid ID or timeout
- AD_SEL  out  [N_SLAVE-1:0]  slave select, combinational
- B_BUS_OUT  out  1  owner's M_BUS_OUT during CONNECT, else 0
- B_RW  out  1  owner's M_RW during CONNECT, else 0
- S_BUS_IN  in  [N_SLAVE-1:0]  serial bit from each slave
- S_ACK  in  [N_SLAVE-1:0]  ACK from each slave
- S_SBSY  in  [N_SLAVE-1:0]  busy from each slave

Behaviour:
- Reset: state IDLE; M_GNT=0; M_ERR=0; last_owner=1 (master 0 wins the first tie); id=0; sbsy_seen=0; timer=0. All combinational outputs are therefore 0.
- IDLE:
  - If any M_REQ is high, grant on the next edge: M_GNT[k]=1, owner=k, go to SLVID.
  - If both request, the master that is not last_owner wins.
- SLVID (ID_BITS cycles):
  - Sample M_BUS_OUT[owner] into id, LSB first, one bit per cycle starting the first cycle M_GNT is high.
  - After the last bit: if id >= N_SLAVE, pulse M_ERR[owner] and go to RELEASE; otherwise go to CONNECT with timer=0.
- CONNECT:
  - AD_SEL[id] = M_REQ[owner] & !(sbsy_seen & !S_SBSY[id]); all other AD_SEL bits are 0.
  - Routing is combinational, with no added latency: B_BUS_OUT, B_RW from the owner; M_BUS_IN[owner]=S_BUS_IN[id]; M_ACK[owner]=S_ACK[id]; M_SBSY[owner]=S_SBSY[id].
  - sbsy_seen is set the first cycle S_SBSY[id]=1.
  - timer increments while sbsy_seen=0. If timer reaches TIMEOUT, pulse M_ERR[owner] and go to RELEASE.
  - Exit to RELEASE on: owner drops M_REQ, or sbsy_seen & !S_SBSY[id] (slave returned to idle). AD_SEL drops in that same cycle so the slave cannot restart.
- RELEASE (1 cycle):
  - M_GNT=0, last_owner=owner, sbsy_seen=0, then IDLE.
  - The grant gap between back-to-back transactions is therefore at least 2 cycles.
- Owner drops M_REQ during SLVID: abandon, go to RELEASE, no M_ERR.
- The non-owner's M_REQ is ignored until IDLE. A request never preempts an active owner.
- M_ERR and M_GNT are never asserted for both masters at once.
- RSTN asserted mid-transaction: everything returns to reset values asynchronously and AD_SEL drops immediately.

Decomposition:
- Shared package bus_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, SLVID, CONNECT, RELEASE}
  - localparam N_SLAVE_DEF=3, ID_BITS_DEF=2
- One sub-module, rr_arbiter2: 2-input round-robin grant from req[1:0] and last_owner.
- Reuse the existing counter module for timer and ID bit count.

Test Plan:
- Single request: M_REQ=01, ID bits 1,0 (id=1) -> M_GNT=01 one cycle after REQ, AD_SEL=010 on the 3rd grant cycle; S_ACK[1] pulse appears on M_ACK[0]; S_SBSY[1] 1→0 drops AD_SEL the same cycle; M_GNT=00 next cycle.
- Simultaneous requests after reset: M_REQ=11 -> master 0 granted. On completion master 1 is granted after the RELEASE cycle. Next tie goes to master 0.
- Invalid ID: master 1 sends id=3 with N_SLAVE=3 -> M_ERR=10 for 1 cycle, no AD_SEL ever asserted, bus free 1 cycle later.
- Timeout: id=2, S_SBSY[2] held 0 -> M_ERR pulses after exactly 255 CONNECT cycles; AD_SEL[2] falls.
- Read data routing: S_BUS_IN[0] drives pattern 8'hA5 during CONNECT -> M_BUS_IN[owner] shows the identical bits the same cycle; non-owner M_BUS_IN stays 0.
- Reset mid-CONNECT: RSTN low -> M_GNT, AD_SEL, M_ERR are 0 without a clock edge; after release a fresh request is granted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared state encoding and parameter defaults for the serial bus arbiter.
package bus_pkg;

    typedef enum logic [2:0] {IDLE, SLVID, CONNECT, RELEASE} arb_state_t;

    localparam int N_SLAVE_DEF = 3;
    localparam int ID_BITS_DEF = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: on a tie the master that did not own the bus last wins.
module rr_arbiter2 (
    input  logic       last_owner_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    always_comb begin
        owner_o = 1'b0;
        if (req_i == 2'b11) begin
            owner_o = ~last_owner_i;
        end else if (req_i == 2'b10) begin
            owner_o = 1'b1;
        end
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o = owner_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter/router for the serial bus: grants one master, takes a serial slave ID,
// then wires the owner to that slave until the transaction ends.
//   state   | meaning
//   IDLE    | no owner; next request is granted on the following edge
//   SLVID   | owner shifts in the slave ID, LSB first
//   CONNECT | owner routed to the selected slave; timeout runs until SBSY is seen
//   RELEASE | grant dropped for one cycle, round-robin history updated
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_SLAVE = N_SLAVE_DEF,
    parameter int ID_BITS = ID_BITS_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [1:0]         M_REQ,
    output logic [1:0]         M_GNT,
    input  logic [1:0]         M_BUS_OUT,
    input  logic [1:0]         M_RW,
    output logic [1:0]         M_BUS_IN,
    output logic [1:0]         M_ACK,
    output logic [1:0]         M_SBSY,
    output logic [1:0]         M_ERR,
    output logic [N_SLAVE-1:0] AD_SEL,
    output logic               B_BUS_OUT,
    output logic               B_RW,
    input  logic [N_SLAVE-1:0] S_BUS_IN,
    input  logic [N_SLAVE-1:0] S_ACK,
    input  logic [N_SLAVE-1:0] S_SBSY
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (ID_BITS > 1) ? $clog2(ID_BITS) : 1;

    arb_state_t         state_q;
    logic [1:0]         gnt_q, err_q;
    logic               owner_q, last_owner_q, sbsy_seen_q;
    logic [ID_BITS-1:0] id_q, id_d;
    logic [CW-1:0]      bitcnt_q;
    logic [TW-1:0]      timer_q, timer_d;

    logic [1:0] rr_gnt, owner_oh;
    logic       rr_owner, connect, sel_bus_in, sel_ack, sel_sbsy;
    logic       slave_done, id_invalid, timed_out;

    rr_arbiter2 u_rr (
        .last_owner_i (last_owner_q),
        .req_i        (M_REQ),
        .gnt_o        (rr_gnt),
        .owner_o      (rr_owner)
    );

    always_comb begin
        id_d           = id_q;
        id_d[bitcnt_q] = M_BUS_OUT[owner_q];
    end

    assign id_invalid = (int'(id_d) >= N_SLAVE);
    assign timer_d    = timer_q + TW'(1);
    assign timed_out  = (timer_d == TW'(TIMEOUT));
    assign connect    = (state_q == CONNECT);
    assign owner_oh   = owner_q ? 2'b10 : 2'b01;
    assign slave_done = sbsy_seen_q & ~sel_sbsy;

    // AD_SEL stays combinational so it drops in the very cycle the slave goes idle again.
    always_comb begin
        sel_bus_in = 1'b0;
        sel_ack    = 1'b0;
        sel_sbsy   = 1'b0;
        AD_SEL     = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            if (id_q == ID_BITS'(s)) begin
                sel_bus_in = S_BUS_IN[s];
                sel_ack    = S_ACK[s];
                sel_sbsy   = S_SBSY[s];
                AD_SEL[s]  = connect & M_REQ[owner_q] & ~(sbsy_seen_q & ~S_SBSY[s]);
            end
        end
    end

    assign M_GNT     = gnt_q;
    assign M_ERR     = err_q;
    assign B_BUS_OUT = connect & M_BUS_OUT[owner_q];
    assign B_RW      = connect & M_RW[owner_q];
    assign M_BUS_IN  = (connect & sel_bus_in) ? owner_oh : 2'b00;
    assign M_ACK     = (connect & sel_ack)    ? owner_oh : 2'b00;
    assign M_SBSY    = (connect & sel_sbsy)   ? owner_oh : 2'b00;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            err_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            id_q         <= '0;
            bitcnt_q     <= '0;
            sbsy_seen_q  <= 1'b0;
            timer_q      <= '0;
        end else begin
            err_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (M_REQ != 2'b00) begin
                        gnt_q    <= rr_gnt;
                        owner_q  <= rr_owner;
                        id_q     <= '0;
                        bitcnt_q <= '0;
                        state_q  <= SLVID;
                    end
                end
                SLVID: begin
                    if (!M_REQ[owner_q]) begin
                        gnt_q   <= 2'b00;
                        state_q <= RELEASE;
                    end else begin
                        id_q <= id_d;
                        if (bitcnt_q == CW'(ID_BITS - 1)) begin
                            if (id_invalid) begin
                                err_q   <= owner_oh;
                                gnt_q   <= 2'b00;
                                state_q <= RELEASE;
                            end else begin
                                timer_q     <= '0;
                                sbsy_seen_q <= 1'b0;
                                state_q     <= CONNECT;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + CW'(1);
                        end
                    end
                end
                CONNECT: begin
                    if (sel_sbsy) begin
                        sbsy_seen_q <= 1'b1;
                    end
                    if (!M_REQ[owner_q] || slave_done) begin
                        gnt_q   <= 2'b00;
                        state_q <= RELEASE;
                    end else if (!sbsy_seen_q && !sel_sbsy) begin
                        timer_q <= timer_d;
                        if (timed_out) begin
                            err_q   <= owner_oh;
                            gnt_q   <= 2'b00;
                            state_q <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    last_owner_q <= owner_q;
                    sbsy_seen_q  <= 1'b0;
                    timer_q      <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: the driver queues cycle-stamped expected outputs,
// the monitor compares every cycle in which the DUT shows any non-zero output.
module tb_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [1:0] m_req, m_bus_out, m_rw;
    logic [1:0] m_gnt, m_bus_in, m_ack, m_sbsy, m_err;
    logic [2:0] ad_sel, s_bus_in, s_ack, s_sbsy;
    logic       b_bus_out, b_rw;
    logic [14:0] obs;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [14:0] outs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;
    logic [7:0] pat;

    bus_arbiter #(.N_SLAVE(3), .ID_BITS(2), .TIMEOUT(255)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .M_REQ     (m_req),
        .M_GNT     (m_gnt),
        .M_BUS_OUT (m_bus_out),
        .M_RW      (m_rw),
        .M_BUS_IN  (m_bus_in),
        .M_ACK     (m_ack),
        .M_SBSY    (m_sbsy),
        .M_ERR     (m_err),
        .AD_SEL    (ad_sel),
        .B_BUS_OUT (b_bus_out),
        .B_RW      (b_rw),
        .S_BUS_IN  (s_bus_in),
        .S_ACK     (s_ack),
        .S_SBSY    (s_sbsy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign obs = {m_gnt, m_err, ad_sel, m_bus_in, m_ack, m_sbsy, b_bus_out, b_rw};

    always @(negedge CLK) begin
        if (RSTN) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < 32'(cyc)) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: nothing seen at cycle %0d, required outputs %h",
                         name_q[0], exp_q[0].cyc, exp_q[0].outs);
                exp_q.delete(0);
                name_q.delete(0);
            end
            if (obs != '0) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: cycle %0d outputs %h, required none", cyc, obs);
                end else begin
                    mon_e  = exp_q[0];
                    mon_nm = name_q[0];
                    exp_q.delete(0);
                    name_q.delete(0);
                    if (mon_e.cyc != 32'(cyc) || mon_e.outs != obs) begin
                        n_fail++;
                        $display("FAIL %s: cycle %0d outputs %h, required cycle %0d outputs %h",
                                 mon_nm, cyc, obs, mon_e.cyc, mon_e.outs);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, bo, rw, input logic [2:0] sbi, sak, ssb);
        m_req     = req;
        m_bus_out = bo;
        m_rw      = rw;
        s_bus_in  = sbi;
        s_ack     = sak;
        s_sbsy    = ssb;
    endtask

    // Output order: gnt, err, ad_sel, bus_in, ack, sbsy, b_bus_out, b_rw
    task automatic exp_out(input string nm, input logic [1:0] gnt, err, input logic [2:0] ad,
                           input logic [1:0] bin, ack, sb, input logic bbo, brw);
        exp_t e;
        e.cyc  = 32'(cyc);
        e.outs = {gnt, err, ad, bin, ack, sb, bbo, brw};
        if (e.outs != '0) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    initial begin
        pat  = 8'hA5;
        RSTN = 1'b0;
        drive(2'b11, 2'b11, 2'b11, 3'b111, 3'b111, 3'b111);
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", 32'(obs), 32'h0);
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        #2 RSTN = 1'b1;
        tick();

        // Tie after reset: master 0 first, master 1 after RELEASE, next tie back to master 0.
        drive(2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        drive(2'b11, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("tie_gnt_m0_b0", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("tie_gnt_m0_b1", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 2'b10, 2'b10, 3'b000, 3'b000, 3'b000);
        exp_out("tie_m0_connect", 2'b01, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b10, 2'b10, 3'b000, 3'b000, 3'b000);
        exp_out("tie_m0_drop", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        tick();
        exp_out("tie_gnt_m1_b0", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("tie_gnt_m1_b1", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("m1_connect_id2", 2'b10, 2'b00, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("m1_drop", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        tick();
        exp_out("tie2_gnt_m0", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();

        // Owner abandons during SLVID: no error, master 1 picked up afterwards.
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("slvid_abort", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        tick();
        tick();

        // Invalid ID 3 from master 1.
        drive(2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("inv_gnt_b0", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        exp_out("inv_gnt_b1", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("inv_err", 2'b00, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();

        // Single request, id=1, ACK and SBSY handshake.
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        drive(2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("s1_gnt_b0", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("s1_gnt_b1", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b01, 2'b01, 2'b01, 3'b000, 3'b000, 3'b000);
        exp_out("s1_connect", 2'b01, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1); tick();
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b010, 3'b010);
        exp_out("s1_ack", 2'b01, 2'b00, 3'b010, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0); tick();
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b010);
        exp_out("s1_busy", 2'b01, 2'b00, 3'b010, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0); tick();
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("s1_slave_idle", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();

        // Read data routing from slave 0, pattern A5 MSB first.
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        exp_out("rd_gnt_b0", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        exp_out("rd_gnt_b1", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        for (int i = 7; i >= 0; i--) begin
            drive(2'b01, {1'b1, ~pat[i]}, 2'b00, {2'b11, pat[i]}, 3'b000, 3'b000);
            exp_out("rd_bit", 2'b01, 2'b00, 3'b001, {1'b0, pat[i]}, 2'b00, 2'b00, ~pat[i], 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("rd_drop", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        tick();

        // Timeout: id=2, slave never busy, exactly 255 CONNECT cycles.
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        exp_out("to_gnt_b0", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("to_gnt_b1", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 255; i++) begin
            exp_out("to_connect", 2'b10, 2'b00, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("to_err", 2'b00, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        tick();

        // Reset in the middle of CONNECT.
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        drive(2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("rst_gnt_b0", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("rst_gnt_b1", 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        exp_out("rst_connect", 2'b01, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        #2 RSTN = 1'b0;
        #1;
        check("rst_async_gnt", 32'(m_gnt), 32'h0);
        check("rst_async_adsel", 32'(ad_sel), 32'h0);
        check("rst_async_err", 32'(m_err), 32'h0);
        check("rst_queue_drained", 32'(exp_q.size()), 32'h0);
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        @(posedge CLK);
        #3 RSTN = 1'b1;
        tick();

        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000); tick();
        exp_out("post_rst_gnt_b0", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        exp_out("post_rst_gnt_b1", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 3'b000);
        exp_out("post_rst_ack", 2'b10, 2'b00, 3'b001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
        exp_out("post_rst_drop", 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        repeat (3) tick();

        check("queue_empty_at_end", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
